// File: rtl/alu_op_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer_if
//
// Purpose: bundles the request channel, the response channel and the ALU
// drive/return bus of the ALU operation sequencer.
//
// Handshake rule, both channels: a transfer happens at a rising edge where
// valid and ready are both 1. A valid source holds its payload stable until
// that edge. Valid never waits on ready. Ready may be asserted without valid.
//
// Signals:
//   ReqValid/ReqReady/ReqOp/ReqA/ReqB   request channel (op + operands)
//   RspValid/RspReady/RspData/RspZero/RspErr  response channel
//   ALUOp/ALUA/ALUB   registered drive into the 2-bit-opcode ALU
//   ALUResult         combinational result returned by the ALU
//
// Modports:
//   master  the sequencer. It initiates ALU operations, serves requests and
//           sources responses.
//   slave   the environment. This is the requester, the response consumer
//           and the ALU.
// ----------------------------------------------------------------------------
interface alu_op_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             ReqValid;
    logic             ReqReady;
    logic [2:0]       ReqOp;
    logic [WIDTH-1:0] ReqA;
    logic [WIDTH-1:0] ReqB;

    logic [1:0]       ALUOp;
    logic [WIDTH-1:0] ALUA;
    logic [WIDTH-1:0] ALUB;
    logic [WIDTH-1:0] ALUResult;

    logic             RspValid;
    logic             RspReady;
    logic [WIDTH-1:0] RspData;
    logic             RspZero;
    logic             RspErr;

    modport master (
        input  ReqValid, ReqOp, ReqA, ReqB, ALUResult, RspReady,
        output ReqReady, ALUOp, ALUA, ALUB, RspValid, RspData, RspZero, RspErr
    );

    modport slave (
        output ReqValid, ReqOp, ReqA, ReqB, ALUResult, RspReady,
        input  ReqReady, ALUOp, ALUA, ALUB, RspValid, RspData, RspZero, RspErr
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer
//
// Purpose: initiator side of the ALU. It accepts one operation request at a
// time and drives ALUOp/ALUA/ALUB into the ALU. It captures ALUResult and
// returns it with zero/error status. The multiply operation (op 100) is an
// unsigned shift-and-add. It iterates ALU add operations and keeps the low
// WIDTH bits of A*B.
//
// Ports:
//   Clk        system clock, rising edge
//   Reset      synchronous, active-low reset
//   bus        alu_op_sequencer_if.master. Carries the request channel, the
//              response channel and the ALU bus.
//   dbg_state  current FSM state (0 IDLE, 1 EXEC, 2 MUL, 3 RESP)
//
// Request opcodes: 000 add, 001 sub, 010 sll, 011 srl, 100 mul.
// Opcodes 101-111 are illegal.
// ----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                Clk,
    input  logic                Reset,
    alu_op_sequencer_if.master  bus,
    output logic [1:0]          dbg_state
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic             ready_q;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             rsp_err;

    // Multiply state. acc holds the partial product. mcand is the
    // multiplicand shifted left once per step. mplier is the multiplier
    // shifted right once per step. Its bit 0 selects whether this step's
    // add is kept.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] mcand_nxt;
    logic [WIDTH-1:0] mplier_nxt;
    logic             accept;

    // The ALU is already computing acc + mcand this cycle.
    always_comb begin
        acc_nxt    = mplier[0] ? bus.ALUResult : acc;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
    end

    // ReqReady is registered, so it stays low through the reset cycles. It
    // rises one cycle after release and one cycle after a response handshake.
    assign accept       = ready_q & bus.ReqValid;
    assign bus.ReqReady = ready_q;
    assign bus.RspValid = (state == RESP);
    assign bus.RspData  = rsp_data;
    assign bus.RspZero  = rsp_zero;
    assign bus.RspErr   = rsp_err;
    assign bus.ALUOp    = alu_op;
    assign bus.ALUA     = alu_a;
    assign bus.ALUB     = alu_b;
    assign dbg_state    = state;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= IDLE;
            ready_q  <= 1'b0;
            alu_op   <= 2'b00;
            alu_a    <= '0;
            alu_b    <= '0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        if (!bus.ReqOp[2]) begin
                            // The low two opcode bits map 1:1 onto the ALU opcode.
                            alu_op <= bus.ReqOp[1:0];
                            alu_a  <= bus.ReqA;
                            alu_b  <= bus.ReqB;
                            state  <= EXEC;
                        end else if (bus.ReqOp == 3'b100) begin
                            acc    <= '0;
                            mcand  <= bus.ReqA;
                            mplier <= bus.ReqB;
                            cnt    <= '0;
                            alu_op <= 2'b00;
                            alu_a  <= '0;
                            alu_b  <= bus.ReqA;
                            state  <= MUL;
                        end else begin
                            // Illegal opcode. The ALU bus is left untouched.
                            rsp_data <= '0;
                            rsp_zero <= 1'b0;
                            rsp_err  <= 1'b1;
                            state    <= RESP;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                EXEC: begin
                    rsp_data <= bus.ALUResult;
                    rsp_zero <= (bus.ALUResult == '0);
                    rsp_err  <= 1'b0;
                    state    <= RESP;
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand_nxt;
                    mplier <= mplier_nxt;
                    cnt    <= cnt + 1'b1;
                    alu_a  <= acc_nxt;
                    alu_b  <= mcand_nxt;
                    // Stop once no multiplier bits remain, or when the last
                    // bit position has been processed.
                    if ((mplier_nxt == '0) || (cnt == CNT_LAST)) begin
                        rsp_data <= acc_nxt;
                        rsp_zero <= (acc_nxt == '0);
                        rsp_err  <= 1'b0;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (bus.RspReady) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Purpose: randomized and directed stimulus for alu_op_sequencer. The bench
// also provides a behavioural ALU. Expected responses are queued at
// request acceptance. A negedge monitor pops the queue and compares each
// response, including its latency, and checks that held responses stay
// stable.
// ----------------------------------------------------------------------------
module tb_alu_op_sequencer;
    localparam int W = 32;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    bit         hold_low = 1'b0;
    bit         prev_valid = 1'b0;

    logic [W-1:0] exp_q[$];
    logic         exp_err_q[$];
    int           exp_lat_q[$];
    int           exp_acc_q[$];

    logic [W-1:0] held_data;
    logic         held_zero;
    logic         held_err;

    alu_op_sequencer_if #(.WIDTH(W)) bus ();

    alu_op_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .Clk       (clk),
        .Reset     (reset),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    // Clock and reset

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: 00 add, 01 sub, 10 sll, 11 srl. Shifts use the full B.
    always_comb begin
        case (bus.ALUOp)
            2'b00:   bus.ALUResult = bus.ALUA + bus.ALUB;
            2'b01:   bus.ALUResult = bus.ALUA - bus.ALUB;
            2'b10:   bus.ALUResult = (bus.ALUB >= W) ? '0 : (bus.ALUA << bus.ALUB);
            default: bus.ALUResult = (bus.ALUB >= W) ? '0 : (bus.ALUA >> bus.ALUB);
        endcase
    end

    // Reference model

    function automatic logic [W-1:0] model_result(input logic [2:0] op, input logic [W-1:0] a,
                                                   input logic [W-1:0] b);
        logic [63:0] prod;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return (b >= W) ? '0 : a << b;
            3'd3: return (b >= W) ? '0 : a >> b;
            3'd4: begin
                prod = {32'd0, a} * {32'd0, b};
                return prod[W-1:0];
            end
            default: return '0;
        endcase
    endfunction

    // Cycles from accept edge to RspValid. A value of -1 means the latency
    // is not checked.
    function automatic int model_latency(input logic [2:0] op, input logic [W-1:0] b);
        int msb;
        if (op <= 3'd3) return 1;
        if (op == 3'd4) begin
            msb = 0;
            for (int i = 0; i < W; i++) if (b[i]) msb = i;
            return msb + 1;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Driver tasks: called on a negedge; they return on a negedge.

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        bus.ReqValid = 1'b1;
        bus.ReqOp    = op;
        bus.ReqA     = a;
        bus.ReqB     = b;
        n = 0;
        while (!bus.ReqReady && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ReqReady) begin
            chk("req_accept_timeout", 64'(n), 64'(0));
            bus.ReqValid = 1'b0;
            return;
        end
        chk("accept_without_rsp", 64'(bus.RspValid), 64'(0));
        exp_q.push_back(model_result(op, a, b));
        exp_err_q.push_back(op > 3'd4);
        exp_lat_q.push_back(model_latency(op, b));
        exp_acc_q.push_back(cyc + 1);
        @(negedge clk);
        bus.ReqValid = 1'b0;
        bus.ReqOp    = 3'($urandom_range(0, 7));
        bus.ReqA     = $urandom;
        bus.ReqB     = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.RspValid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'(0));
    endtask

    // Response consumer and scoreboard monitor. RspReady is driven first, so
    // the monitor sees the value that the next rising edge will sample.

    always @(negedge clk) begin
        bus.RspReady = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (!reset) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.RspValid) begin
                if (!prev_valid) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rsp got=%0h exp=none", bus.RspData);
                    end else begin
                        logic [W-1:0] e_data;
                        logic         e_err;
                        int           e_lat;
                        int           e_acc;
                        e_data = exp_q.pop_front();
                        e_err  = exp_err_q.pop_front();
                        e_lat  = exp_lat_q.pop_front();
                        e_acc  = exp_acc_q.pop_front();
                        chk("rsp_data", 64'(bus.RspData), 64'(e_data));
                        chk("rsp_err", 64'(bus.RspErr), 64'(e_err));
                        chk("rsp_zero", 64'(bus.RspZero), 64'(!e_err && (e_data == '0)));
                        if (e_lat >= 0) chk("rsp_latency", 64'(cyc - e_acc), 64'(e_lat));
                    end
                    held_data = bus.RspData;
                    held_zero = bus.RspZero;
                    held_err  = bus.RspErr;
                end else begin
                    chk("hold_data", 64'(bus.RspData), 64'(held_data));
                    chk("hold_zero", 64'(bus.RspZero), 64'(held_zero));
                    chk("hold_err", 64'(bus.RspErr), 64'(held_err));
                end
                chk("req_ready_in_rsp", 64'(bus.ReqReady), 64'(0));
            end
            prev_valid = bus.RspValid;
        end
    end

    // Main sequence

    initial begin
        logic [2:0]  op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [65:0] alu_snap;

        reset        = 1'b0;
        bus.ReqValid = 1'b0;
        bus.ReqOp    = 3'd0;
        bus.ReqA     = '0;
        bus.ReqB     = '0;

        // The outputs must all be 0 while reset is held low.
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(bus.ReqReady), 64'(0));
        chk("rst_rsp_valid", 64'(bus.RspValid), 64'(0));
        chk("rst_rsp_data", 64'(bus.RspData), 64'(0));
        chk("rst_rsp_zero", 64'(bus.RspZero), 64'(0));
        chk("rst_rsp_err", 64'(bus.RspErr), 64'(0));
        chk("rst_alu_op", 64'(bus.ALUOp), 64'(0));
        chk("rst_alu_a", 64'(bus.ALUA), 64'(0));
        chk("rst_alu_b", 64'(bus.ALUB), 64'(0));
        chk("rst_state", 64'(dbg_state), 64'(0));
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 64'(bus.ReqReady), 64'(1));

        // Directed arithmetic and boundary cases.
        issue(3'd0, 32'hFFFF_FFFF, 32'd2);
        issue(3'd1, 32'd3, 32'd5);
        issue(3'd1, 32'd9, 32'd9);
        issue(3'd2, 32'd1, 32'd31);
        issue(3'd3, 32'h8000_0000, 32'd32);
        issue(3'd4, 32'd7, 32'd6);
        issue(3'd4, 32'd5, 32'd0);
        issue(3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();

        // An illegal opcode must leave the ALU bus untouched.
        alu_snap = {bus.ALUOp, bus.ALUA, bus.ALUB};
        issue(3'b110, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (2) @(negedge clk);
        chk("illegal_alu_hold", 64'({bus.ALUOp, bus.ALUA, bus.ALUB} != alu_snap), 64'(0));
        drain();

        // Backpressure: the response is held, and a new request waits.
        hold_low = 1'b1;
        issue(3'd0, 32'd100, 32'd23);
        fork
            issue(3'd1, 32'd50, 32'd8);
            begin
                repeat (6) @(negedge clk);
                hold_low = 1'b0;
            end
        join
        drain();

        // Reset in the middle of a multiply discards the response.
        issue(3'd4, 32'h0000_0003, 32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        chk("mul_in_progress", 64'(dbg_state), 64'(2));
        reset = 1'b0;
        exp_q.delete();
        exp_err_q.delete();
        exp_lat_q.delete();
        exp_acc_q.delete();
        @(negedge clk);
        chk("abort_state", 64'(dbg_state), 64'(0));
        chk("abort_rsp_valid", 64'(bus.RspValid), 64'(0));
        chk("abort_req_ready", 64'(bus.ReqReady), 64'(0));
        chk("abort_alu_b", 64'(bus.ALUB), 64'(0));
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ready_back", 64'(bus.ReqReady), 64'(1));
        repeat (40) @(negedge clk);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            op = 3'($urandom_range(0, 9) > 7 ? $urandom_range(5, 7) : $urandom_range(0, 4));
            a  = $urandom;
            case (op)
                3'd2, 3'd3: b = $urandom_range(0, 40);
                3'd4:       b = $urandom >> $urandom_range(0, 31);
                default:    b = $urandom;
            endcase
            issue(op, a, b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit.
    initial begin
        #400000;
        $display("FAIL global_timeout got=%0t exp=finish", $time);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
